// File: rtl/mw_writeback_pkg.sv
// Shared pipeline definitions for the M->W writeback stage: writeback source
// and load-type encodings, reset PC and load-extension helpers.
package mw_writeback_pkg;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_LOAD = 2'd1,
    WD_PC8  = 2'd2,
    WD_AUX  = 2'd3
  } wdsel_e;

  // Codes 5-7 are reserved and treated as a full-word load.
  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  localparam logic [31:0] RESET_PC       = 32'h0000_3000;
  localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load extender: picks the addressed byte/halfword out of an
// aligned memory word and sign- or zero-extends it.
module load_ext
  import mw_writeback_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte/halfword lane selection and extension; halfwords ignore offset[0].
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    value = word;
    case (load_type)
      LT_LW:   value = word;
      LT_LB:   value = ext8(byte_s, 1'b1);
      LT_LBU:  value = ext8(byte_s, 1'b0);
      LT_LH:   value = ext16(half_s, 1'b1);
      LT_LHU:  value = ext16(half_s, 1'b0);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mw_writeback.sv
// M->W pipeline register: selects the writeback value, suppresses $0 writes,
// handles stall/flush bubbles and counts retired instructions.
module mw_writeback
  import mw_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        M_Valid,
  input  logic [31:0] M_PC,
  input  logic        M_RegWE,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_WDSel,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_MemRD,
  input  logic [31:0] M_Aux,
  input  logic [2:0]  M_LoadType,
  input  logic [1:0]  M_ByteOff,
  output logic        W_RFWE,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic [31:0] W_WPC,
  output logic        W_Valid,
  output logic [31:0] RetireCnt
);

  logic [31:0] load_val_s;
  logic [31:0] wd_s;
  logic        rfwe_s;
  logic        retire_s;

  logic        valid_r;
  logic        rfwe_r;
  logic [4:0]  a3_r;
  logic [31:0] wd_r;
  logic [31:0] wpc_r;
  logic [31:0] retire_cnt_r;

  load_ext u_load_ext (
    .word      (M_MemRD),
    .offset    (M_ByteOff),
    .load_type (M_LoadType),
    .value     (load_val_s)
  );

  // Writeback source mux ahead of the W register.
  always_comb begin
    wd_s = M_ALUOut;
    case (M_WDSel)
      WD_ALU:  wd_s = M_ALUOut;
      WD_LOAD: wd_s = load_val_s;
      WD_PC8:  wd_s = M_PC + PC_LINK_OFFSET;
      WD_AUX:  wd_s = M_Aux;
      default: wd_s = M_ALUOut;
    endcase
  end

  assign rfwe_s   = M_Valid & M_RegWE & (M_A3 != 5'd0);
  // The instruction in W leaves on any edge it is not held by a plain stall.
  assign retire_s = valid_r & (~stall | flush);

  // W register and retirement counter; flush beats stall, bubble keeps PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r      <= 1'b0;
      rfwe_r       <= 1'b0;
      a3_r         <= 5'd0;
      wd_r         <= 32'd0;
      wpc_r        <= RESET_PC;
      retire_cnt_r <= 32'd0;
    end else begin
      if (retire_s) begin
        retire_cnt_r <= retire_cnt_r + 32'd1;
      end
      if (flush) begin
        valid_r <= 1'b0;
        rfwe_r  <= 1'b0;
        a3_r    <= 5'd0;
        wd_r    <= 32'd0;
      end else if (!stall) begin
        valid_r <= M_Valid;
        rfwe_r  <= rfwe_s;
        a3_r    <= M_A3;
        wd_r    <= wd_s;
        wpc_r   <= M_PC;
      end
    end
  end

  assign W_Valid   = valid_r;
  assign W_RFWE    = rfwe_r;
  assign W_A3      = a3_r;
  assign W_WD      = wd_r;
  assign W_WPC     = wpc_r;
  assign RetireCnt = retire_cnt_r;

endmodule

// File: tb/tb_mw_writeback.sv
// Self-checking bench for mw_writeback: vector table through a scoreboard,
// plus stall/flush, counter-wrap and mid-stream reset sequences.
module tb_mw_writeback;
  import mw_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        M_Valid, M_RegWE;
  logic [31:0] M_PC, M_ALUOut, M_MemRD, M_Aux;
  logic [4:0]  M_A3;
  logic [1:0]  M_WDSel, M_ByteOff;
  logic [2:0]  M_LoadType;
  logic        W_RFWE, W_Valid;
  logic [4:0]  W_A3;
  logic [31:0] W_WD, W_WPC, RetireCnt;

  mw_writeback dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .M_Valid(M_Valid), .M_PC(M_PC), .M_RegWE(M_RegWE), .M_A3(M_A3),
    .M_WDSel(M_WDSel), .M_ALUOut(M_ALUOut), .M_MemRD(M_MemRD), .M_Aux(M_Aux),
    .M_LoadType(M_LoadType), .M_ByteOff(M_ByteOff),
    .W_RFWE(W_RFWE), .W_A3(W_A3), .W_WD(W_WD), .W_WPC(W_WPC),
    .W_Valid(W_Valid), .RetireCnt(RetireCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, regwe;
    logic [4:0]  a3;
    logic [1:0]  wdsel, boff;
    logic [2:0]  ltype;
    logic [31:0] pc, alu, memrd, aux;
    logic        exp_rfwe;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic        valid, rfwe;
    logic [4:0]  a3;
    logic [31:0] wd, wpc;
  } exp_t;

  vec_t        vecs[18];
  exp_t        sbq[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_retire;
  logic        w_valid_model;

  localparam logic [31:0] MW = 32'h80FF_7F01;

  function automatic vec_t mk(input logic v, input logic we, input logic [4:0] a3,
                              input logic [1:0] ws, input logic [2:0] lt, input logic [1:0] bo,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] aux, input logic erf, input logic [31:0] ewd);
    vec_t r;
    r.valid = v; r.regwe = we; r.a3 = a3; r.wdsel = ws; r.ltype = lt; r.boff = bo;
    r.pc = pc; r.alu = alu; r.memrd = MW; r.aux = aux; r.exp_rfwe = erf; r.exp_wd = ewd;
    return r;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    M_Valid = v.valid; M_RegWE = v.regwe; M_A3 = v.a3; M_WDSel = v.wdsel;
    M_LoadType = v.ltype; M_ByteOff = v.boff; M_PC = v.pc; M_ALUOut = v.alu;
    M_MemRD = v.memrd; M_Aux = v.aux;
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.valid = v.valid; e.rfwe = v.exp_rfwe; e.a3 = v.a3; e.wd = v.exp_wd; e.wpc = v.pc;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk32({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk32({tag, " W_Valid"}, {31'd0, W_Valid}, {31'd0, e.valid});
      chk32({tag, " W_RFWE"},  {31'd0, W_RFWE},  {31'd0, e.rfwe});
      chk32({tag, " W_A3"},    {27'd0, W_A3},    {27'd0, e.a3});
      chk32({tag, " W_WD"},    W_WD,             e.wd);
      chk32({tag, " W_WPC"},   W_WPC,            e.wpc);
    end
  endtask

  task automatic edge_model(input logic st, input logic fl, input logic mvalid);
    if (w_valid_model && (!st || fl)) exp_retire = exp_retire + 32'd1;
    if (fl) w_valid_model = 1'b0;
    else if (!st) w_valid_model = mvalid;
  endtask

  task automatic check_reset_vals(input string tag);
    chk32({tag, " W_Valid"},   {31'd0, W_Valid}, 32'd0);
    chk32({tag, " W_RFWE"},    {31'd0, W_RFWE},  32'd0);
    chk32({tag, " W_A3"},      {27'd0, W_A3},    32'd0);
    chk32({tag, " W_WD"},      W_WD,             32'd0);
    chk32({tag, " W_WPC"},     W_WPC,            32'h0000_3000);
    chk32({tag, " RetireCnt"}, RetireCnt,        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a;
    vec_t b;
    vecs[0]  = mk(1'b1, 1'b1, 5'd5,  2'd1, 3'd1, 2'd3, 32'h0000_3000, 32'd0, 32'd0, 1'b1, 32'hFFFF_FF80);
    vecs[1]  = mk(1'b1, 1'b1, 5'd5,  2'd1, 3'd2, 2'd3, 32'h0000_3004, 32'd0, 32'd0, 1'b1, 32'h0000_0080);
    vecs[2]  = mk(1'b1, 1'b1, 5'd6,  2'd1, 3'd1, 2'd0, 32'h0000_3008, 32'd0, 32'd0, 1'b1, 32'h0000_0001);
    vecs[3]  = mk(1'b1, 1'b1, 5'd6,  2'd1, 3'd1, 2'd1, 32'h0000_300C, 32'd0, 32'd0, 1'b1, 32'h0000_007F);
    vecs[4]  = mk(1'b1, 1'b1, 5'd6,  2'd1, 3'd1, 2'd2, 32'h0000_3010, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    vecs[5]  = mk(1'b1, 1'b1, 5'd8,  2'd1, 3'd4, 2'd3, 32'h0000_3014, 32'd0, 32'd0, 1'b1, 32'h0000_80FF);
    vecs[6]  = mk(1'b1, 1'b1, 5'd8,  2'd1, 3'd3, 2'd3, 32'h0000_3018, 32'd0, 32'd0, 1'b1, 32'hFFFF_80FF);
    vecs[7]  = mk(1'b1, 1'b1, 5'd8,  2'd1, 3'd3, 2'd1, 32'h0000_301C, 32'd0, 32'd0, 1'b1, 32'h0000_7F01);
    vecs[8]  = mk(1'b1, 1'b1, 5'd8,  2'd1, 3'd4, 2'd2, 32'h0000_3020, 32'd0, 32'd0, 1'b1, 32'h0000_80FF);
    vecs[9]  = mk(1'b1, 1'b1, 5'd9,  2'd1, 3'd0, 2'd2, 32'h0000_3024, 32'd0, 32'd0, 1'b1, 32'h80FF_7F01);
    vecs[10] = mk(1'b1, 1'b1, 5'd9,  2'd1, 3'd7, 2'd3, 32'h0000_3028, 32'd0, 32'd0, 1'b1, 32'h80FF_7F01);
    vecs[11] = mk(1'b1, 1'b1, 5'd9,  2'd2, 3'd0, 2'd0, 32'h0000_3004, 32'd0, 32'd0, 1'b1, 32'h0000_300C);
    vecs[12] = mk(1'b1, 1'b1, 5'd0,  2'd2, 3'd0, 2'd0, 32'h0000_3004, 32'd0, 32'd0, 1'b0, 32'h0000_300C);
    vecs[13] = mk(1'b1, 1'b1, 5'd10, 2'd0, 3'd1, 2'd3, 32'h0000_3030, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);
    vecs[14] = mk(1'b1, 1'b1, 5'd11, 2'd3, 3'd1, 2'd3, 32'h0000_3034, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    vecs[15] = mk(1'b0, 1'b1, 5'd7,  2'd0, 3'd0, 2'd0, 32'h0000_3038, 32'hAAAA_5555, 32'd0, 1'b0, 32'hAAAA_5555);
    vecs[16] = mk(1'b1, 1'b0, 5'd12, 2'd2, 3'd0, 2'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 32'h0000_0004);
    vecs[17] = mk(1'b1, 1'b1, 5'd31, 2'd1, 3'd2, 2'd0, 32'h0000_3040, 32'd0, 32'd0, 1'b1, 32'h0000_0001);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    exp_retire = 32'd0; w_valid_model = 1'b0;
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Main table: one new instruction per cycle, no stall or flush.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      push(vecs[i]);
      @(posedge clk);
      #1;
      edge_model(1'b0, 1'b0, vecs[i].valid);
      check_pop($sformatf("vec%0d", i));
      chk32($sformatf("vec%0d RetireCnt", i), RetireCnt, exp_retire);
      @(negedge clk);
    end

    // Stall for three cycles, then flush+stall together.
    a = mk(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0000_0100, 32'h0000_1111, 32'd0, 1'b1, 32'h0000_1111);
    b = mk(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h0000_0200, 32'h0000_2222, 32'd0, 1'b1, 32'h0000_2222);
    drive(a);
    @(posedge clk); #1;
    edge_model(1'b0, 1'b0, 1'b1);
    chk32("stall-load RetireCnt", RetireCnt, exp_retire);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1; drive(b);
      @(posedge clk); #1;
      edge_model(1'b1, 1'b0, 1'b1);
      chk32($sformatf("stall%0d W_WD", i), W_WD, 32'h0000_1111);
      chk32($sformatf("stall%0d W_A3", i), {27'd0, W_A3}, 32'd3);
      chk32($sformatf("stall%0d W_Valid", i), {31'd0, W_Valid}, 32'd1);
      chk32($sformatf("stall%0d W_WPC", i), W_WPC, 32'h0000_0100);
      chk32($sformatf("stall%0d RetireCnt", i), RetireCnt, exp_retire);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    edge_model(1'b1, 1'b1, 1'b1);
    chk32("flush W_Valid", {31'd0, W_Valid}, 32'd0);
    chk32("flush W_RFWE", {31'd0, W_RFWE}, 32'd0);
    chk32("flush W_A3", {27'd0, W_A3}, 32'd0);
    chk32("flush W_WD", W_WD, 32'd0);
    chk32("flush W_WPC", W_WPC, 32'h0000_0100);
    chk32("flush RetireCnt", RetireCnt, exp_retire);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    edge_model(1'b0, 1'b1, 1'b1);
    chk32("flush-bubble RetireCnt", RetireCnt, exp_retire);

    // Counter wrap: preset to all-ones, then two retirements.
    @(negedge clk);
    flush = 1'b0;
    drive(a);
    dut.retire_cnt_r = 32'hFFFF_FFFF;
    exp_retire = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      edge_model(1'b0, 1'b0, 1'b1);
      chk32($sformatf("wrap%0d RetireCnt", i), RetireCnt, exp_retire);
      @(negedge clk);
    end
    chk32("wrap final RetireCnt", RetireCnt, 32'h0000_0001);

    // Reset pulse between edges with a valid instruction in W.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("midreset");
    #1 reset = 1'b0;
    exp_retire = 32'd0; w_valid_model = 1'b0;
    sbq.delete();
    @(negedge clk);
    drive(vecs[6]);
    push(vecs[6]);
    @(posedge clk); #1;
    edge_model(1'b0, 1'b0, 1'b1);
    check_pop("postreset");
    chk32("postreset RetireCnt", RetireCnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mw_writeback.md
MW_WRITEBACK -- requirements
Module: mw_writeback

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port stall, input, 1: hold W register contents.
REQ-004 SHALL have port flush, input, 1: load a bubble into the W register.
REQ-005 SHALL have port M_Valid, input, 1: M-stage instruction is real, not a bubble.
REQ-006 SHALL have port M_PC, input, 32: M-stage instruction PC.
REQ-007 SHALL have port M_RegWE, input, 1: instruction writes a GPR.
REQ-008 SHALL have port M_A3, input, 5: destination GPR index.
REQ-009 SHALL have port M_WDSel, input, 2: writeback source; 0=ALU, 1=load, 2=PC+8, 3=aux.
REQ-010 SHALL have ports M_ALUOut, M_MemRD and M_Aux, input, 32 each: ALU result, raw aligned memory word, HI/LO/aux value.
REQ-011 SHALL have port M_LoadType, input, 3: 0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5-7 reserved.
REQ-012 SHALL have port M_ByteOff, input, 2: effective-address bits [1:0].
REQ-013 SHALL have ports W_RFWE (1), W_A3 (5), W_WD (32) and W_WPC (32), output: register-file write port and trace PC.
REQ-014 SHALL have port W_Valid, output, 1: W holds a real instruction.
REQ-015 SHALL have port RetireCnt, output, 32: count of retired real instructions.

Function
REQ-016 SHALL make every output a register output; no combinational path from any input to any output.
REQ-017 SHALL have a latency of 1 cycle: M values sampled at edge N appear on W outputs after edge N.
REQ-018 SHALL select the data value before latching: ALU gives M_ALUOut; load gives the extended value (REQ-019); PC+8 gives M_PC+8 modulo 2^32; aux gives M_Aux.
REQ-019 SHALL extend loads as follows: lw returns M_MemRD unchanged; lb/lbu take byte M_ByteOff (byte 0 = bits 7:0), sign- or zero-extended; lh/lhu take the halfword at M_ByteOff[1] and ignore M_ByteOff[0], sign- or zero-extended; reserved types behave as lw.
REQ-020 SHALL latch W_RFWE as M_Valid & M_RegWE & (M_A3 != 0), so writes to $0 are never issued.
REQ-021 SHALL behave as follows on each edge when not in reset: if flush, load a bubble; else if stall, hold all W registers; else load M values.
REQ-022 SHALL give a flush asserted together with stall priority, so a bubble is loaded.
REQ-023 SHALL define a bubble as W_Valid=0, W_RFWE=0, W_A3=0, W_WD=0, with W_WPC keeping its previous value.
REQ-024 SHALL increment RetireCnt by 1 on each edge where a real instruction leaves W, i.e. W_Valid=1 and (not stall or flush).
REQ-025 SHALL wrap RetireCnt from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-026 SHALL hold RetireCnt unchanged during stall with no flush.

Reset
REQ-027 SHALL, while reset=1 and regardless of clk, drive W_Valid=0, W_RFWE=0, W_A3=0, W_WD=0, W_WPC=0x00003000 and RetireCnt=0.
REQ-028 SHALL discard an instruction in flight when reset is asserted mid-operation; it is not counted.
REQ-029 SHALL sample normally at the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place the WDSel encodings, LoadType encodings and the reset PC constant 0x00003000 in the shared pipeline package.
REQ-031 SHALL implement load extension as one combinational sub-module, load_ext (inputs word, offset, type; output 32-bit value).

Verification
REQ-032 SHALL cover: lb with M_MemRD=0x80FF7F01, ByteOff=3, Valid, RegWE, A3=5 -> next edge W_WD=0xFFFFFF80, W_RFWE=1, W_A3=5.
REQ-033 SHALL cover: lhu with same word, ByteOff=3 -> W_WD=0x000080FF; lh -> 0xFFFF80FF.
REQ-034 SHALL cover: WDSel=2 with M_PC=0x00003004 -> W_WD=0x0000300C; same with A3=0 -> W_RFWE=0.
REQ-035 SHALL cover: stall held 3 cycles then flush+stall together -> outputs hold 3 cycles, then bubble; RetireCnt +1 only at the flush edge when W_Valid=1.
REQ-036 SHALL cover: RetireCnt preset near wrap via 2 retirements from 0xFFFFFFFF -> reads 0x00000001.
REQ-037 SHALL cover: reset pulsed between clock edges mid-stream -> outputs reach reset values before the next edge; first post-reset edge loads M values.
